fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
Write-domain pointer and status generator for the asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory and drives its write address and write enable. It keeps the binary and Gray write pointers and compares them against the read pointer already synchronised into the write domain. From that it produces full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDR, 3, address width; DEPTH = 1<<ADDR entries; legal range ADDR >= 2.
AF_MARGIN, 2, almost-full asserts when free entries <= AF_MARGIN; legal range 1..DEPTH-1.

Ports:
wclk  input  1  write-domain clock.
wrst  input  1  asynchronous, active-high reset.
winc  input  1  write request for this cycle.
wq2_rptr  input  ADDR+1  Gray read pointer, already 2-flop synchronised into wclk.
wovf_clr  input  1  clears the sticky overflow flag.
waddr  output  ADDR  memory write address.
wclken  output  1  memory write enable.
wptr  output  ADDR+1  registered Gray write pointer, sent to the read-domain synchroniser.
wfull  output  1  FIFO full.
walmost_full  output  1  free entries <= AF_MARGIN.
wlevel  output  ADDR+1  write-side fill estimate, range 0..DEPTH.
woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- One clock, wclk. Reset is asynchronous and active-high: wrst.
- Reset (asynchronous assert, takes effect immediately, also mid-operation): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. Outputs derived from these follow, so waddr=0 and wclken=0.
- Internal binary pointer wbin, ADDR+1 bits.
  - waddr = wbin[ADDR-1:0], taken directly from the register.
- Write enable: wclken = winc & ~wfull, combinational.
- Pointer update on each rising wclk:
  - wbin_next = wbin + wclken, wrapping modulo 2^(ADDR+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - wbin <= wbin_next; wptr <= wgray_next.
- Full flag, registered:
  - wfull <= (wgray_next == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]}).
  - Re-evaluated every cycle, so a change on wq2_rptr alone can deassert wfull one edge later.
  - Full is conservative: the synchronised read pointer lags the true one.
- Level, registered:
  - rbin_s = Gray-to-binary of wq2_rptr.
  - wlevel <= wbin_next - rbin_s, computed in ADDR+1 bits.
  - Wrap-around of either pointer is handled by this modular subtraction.
- Almost full, registered: walmost_full <= (level_next >= DEPTH - AF_MARGIN). Here level_next is the same value being loaded into wlevel.
- Overflow:
  - woverflow <= 1 when winc & wfull; the pointer does not move.
  - Otherwise woverflow <= 0 when wovf_clr.
  - Set has priority over clear when both occur in the same cycle.
- Latency:
  - wptr, wfull, walmost_full and wlevel reflect a write one edge after it.
  - waddr presents the next free slot in the same cycle it becomes current.
- Write exactly when the FIFO becomes full: that write is accepted, and wfull rises at the same edge.
- winc while wfull is high: no memory write, no pointer change.

Decomposition:
- Shared package/include holds:
  - the ADDR and DEPTH localparam relation;
  - bin2gray and gray2bin functions, shared with the read-pointer/empty block;
  - the full-compare pattern helper.
- One sub-module is natural: fifo_gray2bin, a combinational, ADDR+1-wide converter that the read-side block reuses.

Test Plan:
All scenarios use ADDR=3 (DEPTH=8) and AF_MARGIN=2.
1. Reset: pulse wrst between wclk edges mid-fill → all outputs go to 0 immediately, without waiting for an edge; waddr=0.
2. Fill: wq2_rptr=0000, winc=1 for 8 cycles → waddr 0..7, wptr Gray sequence 0001,0011,0010,0110,0111,0101,0100,1100. wfull=1 after the 8th edge; wlevel=8.
3. Almost full: same fill → walmost_full rises after the 6th write edge (wlevel=6) and stays high.
4. Overflow: from full, winc=1 → wptr holds at 1100, wclken=0, woverflow=1. Pulse wovf_clr alone → woverflow=0. Pulse wovf_clr together with winc while full → woverflow remains 1.
5. Drain release: from full, set wq2_rptr=0001 with winc=0 → wfull=0 and wlevel=7 after one edge; walmost_full remains 1.
6. Wrap: 20 writes with wq2_rptr tracking wptr two cycles behind → waddr wraps 7→0, wptr wraps 1000→0000, wfull never asserts, woverflow stays 0.

Source files
------------

// File: rtl/fifo_wptr_full_pkg.sv
// rtl/fifo_wptr_full_pkg.sv - shared pointer helpers for the async FIFO write and read pointer blocks
package fifo_wptr_full_pkg;

  localparam int ADDR_DEFAULT = 3;

  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extension above the pointer width is harmless.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Gray value the write pointer reaches when it is exactly one lap ahead of rptr.
  function automatic logic [31:0] full_pattern(input logic [31:0] rptr, input int addr);
    return rptr ^ (32'd3 << (addr - 1));
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary converter shared by both FIFO pointer blocks
module fifo_gray2bin
  import fifo_wptr_full_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(32'(gray)));

endmodule

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - write-domain pointer, full/almost-full, level and overflow generator
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR      = ADDR_DEFAULT,
  parameter int AF_MARGIN = 2
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic            winc,
  input  logic [ADDR:0]   wq2_rptr,
  input  logic            wovf_clr,
  output logic [ADDR-1:0] waddr,
  output logic            wclken,
  output logic [ADDR:0]   wptr,
  output logic            wfull,
  output logic            walmost_full,
  output logic [ADDR:0]   wlevel,
  output logic            woverflow
);

  localparam int PW    = ADDR + 1;
  localparam int DEPTH = depth_of(ADDR);
  localparam logic [ADDR:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [ADDR:0] wbin;
  logic [ADDR:0] wbin_next;
  logic [ADDR:0] wgray_next;
  logic [ADDR:0] rbin_s;
  logic [ADDR:0] level_next;
  logic [ADDR:0] full_pat;

  fifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  assign waddr      = wbin[ADDR-1:0];
  assign wclken     = winc & ~wfull;
  assign wbin_next  = wbin + {{ADDR{1'b0}}, wclken};
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  assign full_pat   = PW'(full_pattern(32'(wq2_rptr), ADDR));
  // Modular subtraction absorbs wrap of either pointer.
  assign level_next = wbin_next - rbin_s;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_pat);
      walmost_full <= (level_next >= AF_THRESH);
      wlevel       <= level_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - self-checking bench for fifo_wptr_full against a counter-level model
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       winc = 1'b0;
  logic [3:0] wq2_rptr = '0;
  logic       wovf_clr = 1'b0;
  logic [2:0] waddr;
  logic       wclken;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded write/read counts, level taken as their distance.
  int m_wcnt = 0;
  int rd_cnt = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit m_ovf = 0;

  fifo_wptr_full #(.ADDR(3), .AF_MARGIN(2)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wclken       (wclken),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt = 0; rd_cnt = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  // Drive inputs one tick after an edge, settle, leave caller at posedge+2.
  task automatic drive(input logic inc, input logic clr);
    winc = inc;
    wovf_clr = clr;
    wq2_rptr = 4'(gray(rd_cnt & 15));
    #1;
  endtask

  task automatic edge_and_model();
    bit acc;
    @(posedge wclk);
    acc = winc && !m_full;
    if (winc && m_full) m_ovf = 1;
    else if (wovf_clr) m_ovf = 0;
    m_wcnt = m_wcnt + int'(acc);
    m_level = m_wcnt - rd_cnt;
    m_full = (m_level == 8);
    m_af = (m_level >= 6);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    winc = 1'b0;
    wovf_clr = 1'b0;
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      edge_and_model();
    end
    winc = 1'b0;
    wrst = 1'b1;
    #1;
    checks++;
    if ({waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async: got waddr=%0d wclken=%0b wptr=%b wfull=%0b waf=%0b wlevel=%0d wovf=%0b expected all 0",
               waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow);
    end
    #1;
    wrst = 1'b0;
    model_reset();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_fill();
    logic [3:0] gseq [8];
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (waddr !== 3'(i) || wclken !== 1'b1) begin
        errors++;
        $display("FAIL fill_addr[%0d]: got waddr=%0d wclken=%0b expected %0d 1", i, waddr, wclken, i);
      end
      edge_and_model();
      checks++;
      if (wptr !== gseq[i] || wfull !== (i == 7) || wlevel !== 4'(i + 1) || walmost_full !== (i >= 5)) begin
        errors++;
        $display("FAIL fill_state[%0d]: got wptr=%b wfull=%0b wlevel=%0d waf=%0b expected %b %0b %0d %0b",
                 i, wptr, wfull, wlevel, walmost_full, gseq[i], (i == 7), i + 1, (i >= 5));
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0);
    checks++;
    if (wclken !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wclken: got %0b expected 0", wclken);
    end
    edge_and_model();
    checks++;
    if (wptr !== 4'b1100 || woverflow !== 1'b1 || wfull !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got wptr=%b wovf=%0b wfull=%0b expected 1100 1 1", wptr, woverflow, wfull);
    end
    drive(1'b0, 1'b1);
    edge_and_model();
    checks++;
    if (woverflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %0b expected 0", woverflow);
    end
    drive(1'b1, 1'b1);
    edge_and_model();
    checks++;
    if (woverflow !== 1'b1 || wptr !== 4'b1100) begin
      errors++;
      $display("FAIL ovf_set_priority: got wovf=%0b wptr=%b expected 1 1100", woverflow, wptr);
    end
  endtask

  task automatic test_drain();
    rd_cnt = 1;
    drive(1'b0, 1'b1);
    edge_and_model();
    checks++;
    if (wfull !== 1'b0 || wlevel !== 4'd7 || walmost_full !== 1'b1 || woverflow !== 1'b0) begin
      errors++;
      $display("FAIL drain: got wfull=%0b wlevel=%0d waf=%0b wovf=%0b expected 0 7 1 0",
               wfull, wlevel, walmost_full, woverflow);
    end
  endtask

  task automatic test_wrap();
    bit seen_wrap;
    logic [3:0] prev;
    seen_wrap = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rd_cnt = (m_wcnt >= 2) ? m_wcnt - 2 : 0;
      prev = wptr;
      drive(1'b1, 1'b0);
      checks++;
      if (waddr !== 3'(i & 7) || wclken !== 1'b1) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got waddr=%0d wclken=%0b expected %0d 1", i, waddr, wclken, i & 7);
      end
      edge_and_model();
      if (prev == 4'b1000 && wptr == 4'b0000) seen_wrap = 1;
      checks++;
      if (wptr !== 4'(gray((i + 1) & 15)) || wfull !== 1'b0 || woverflow !== 1'b0) begin
        errors++;
        $display("FAIL wrap_state[%0d]: got wptr=%b wfull=%0b wovf=%0b expected %b 0 0",
                 i, wptr, wfull, woverflow, 4'(gray((i + 1) & 15)));
      end
    end
    checks++;
    if (seen_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_gray_1000_0000: got seen=%0b expected 1", seen_wrap);
    end
  endtask

  task automatic test_random();
    bit inc;
    bit clr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) rd_cnt = rd_cnt + $urandom_range(0, m_wcnt - rd_cnt);
      drive(inc, clr);
      checks++;
      if (wclken !== (inc && !m_full) || waddr !== 3'(m_wcnt & 7)) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got wclken=%0b waddr=%0d expected %0b %0d",
                 i, wclken, waddr, (inc && !m_full), m_wcnt & 7);
      end
      edge_and_model();
      checks++;
      if (wptr !== 4'(gray(m_wcnt & 15)) || wfull !== m_full || walmost_full !== m_af ||
          wlevel !== 4'(m_level) || woverflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_state[%0d]: got wptr=%b wfull=%0b waf=%0b wlevel=%0d wovf=%0b expected %b %0b %0b %0d %0b",
                 i, wptr, wfull, walmost_full, wlevel, woverflow,
                 4'(gray(m_wcnt & 15)), m_full, m_af, m_level, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
